expr_eval_ctrl: RTL and testbench

- Streaming controller that consumes an ASCII character stream through a valid/ready handshake.
- Validates the digit-operator grammar `digit ((+|*) digit)*` and evaluates the expression with `*` taking precedence over `+`.
- The expression is terminated by `=` (8'd61); one result/error pulse is then emitted.
- Sits between a character source (UART/keyboard buffer) and the display/result logic; it replaces bare grammar checking with checking plus evaluation.

---
 rtl/expr_eval_ctrl_if.sv | 24 ++
 rtl/expr_eval_ctrl.sv | 139 +++++++++++++
 tb/tb_expr_eval_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/expr_eval_ctrl_if.sv
// rtl/expr_eval_ctrl_if.sv - character-in / result-out handshake bundle for expr_eval_ctrl
`timescale 1ns/1ps
interface expr_eval_ctrl_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic [7:0]   in;
  logic         in_ready;
  logic         res_valid;
  logic [W-1:0] res;
  logic         err;
  logic [7:0]   nops;
  logic         busy;

  modport master (
    output in_valid, in,
    input  in_ready, res_valid, res, err, nops, busy
  );

  modport slave (
    input  in_valid, in,
    output in_ready, res_valid, res, err, nops, busy
  );
endinterface

// File: rtl/expr_eval_ctrl.sv
// rtl/expr_eval_ctrl.sv - streaming grammar check and evaluation of digit (+|*) digit ... = expressions
`timescale 1ns/1ps
module expr_eval_ctrl #(
  parameter int W = 16
) (
  input logic              clk,
  input logic              clr,
  expr_eval_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_OPR, S_DIG, S_ERR, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] sum_q, sum_d, prod_q, prod_d, res_q, res_d;
  logic         op_mul_q, op_mul_d, err_q, err_d;
  logic [7:0]   cnt_q, cnt_d, nops_q, nops_d;

  logic         accept, is_digit, is_plus, is_mul, is_eq;
  logic [W-1:0] dig_w;
  logic [7:0]   cnt_inc;

  assign accept   = bus.in_valid && (state_q != S_DONE);
  assign is_digit = (bus.in >= 8'd48) && (bus.in <= 8'd57);
  assign is_plus  = (bus.in == 8'd43);
  assign is_mul   = (bus.in == 8'd42);
  assign is_eq    = (bus.in == 8'd61);
  // ASCII '0'..'9' are 0x30..0x39, so the low nibble is already the digit value
  assign dig_w    = W'(bus.in[3:0]);
  assign cnt_inc  = (cnt_q == 8'd255) ? 8'd255 : cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    prod_d   = prod_q;
    op_mul_d = op_mul_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    err_d    = err_q;
    nops_d   = nops_q;

    if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_digit) begin
            sum_d   = '0;
            prod_d  = dig_w;
            cnt_d   = 8'd1;
            state_d = S_OPR;
          end else if (is_eq) begin
            res_d   = '0;
            err_d   = 1'b1;
            nops_d  = 8'd0;
            state_d = S_DONE;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_ERR;
          end
        end
        S_OPR: begin
          if (is_plus) begin
            op_mul_d = 1'b0;
            state_d  = S_DIG;
          end else if (is_mul) begin
            op_mul_d = 1'b1;
            state_d  = S_DIG;
          end else if (is_eq) begin
            res_d   = sum_q + prod_q;
            err_d   = 1'b0;
            nops_d  = cnt_q;
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_DIG: begin
          if (is_digit) begin
            // '+' folds the pending product into the sum; '*' keeps extending it
            if (op_mul_q) begin
              prod_d = prod_q * dig_w;
            end else begin
              sum_d  = sum_q + prod_q;
              prod_d = dig_w;
            end
            cnt_d   = cnt_inc;
            state_d = S_OPR;
          end else if (is_eq) begin
            res_d   = '0;
            err_d   = 1'b1;
            nops_d  = cnt_q;
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          if (is_eq) begin
            res_d   = '0;
            err_d   = 1'b1;
            nops_d  = cnt_q;
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      sum_q    <= '0;
      prod_q   <= '0;
      op_mul_q <= 1'b0;
      cnt_q    <= 8'd0;
      res_q    <= '0;
      err_q    <= 1'b0;
      nops_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      prod_q   <= prod_d;
      op_mul_q <= op_mul_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      err_q    <= err_d;
      nops_q   <= nops_d;
    end
  end

  assign bus.in_ready  = (state_q != S_DONE);
  assign bus.res_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.res       = res_q;
  assign bus.err       = err_q;
  assign bus.nops      = nops_q;

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// tb/tb_expr_eval_ctrl.sv - scoreboard bench for expr_eval_ctrl with directed expressions
`timescale 1ns/1ps
module tb_expr_eval_ctrl;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    logic [7:0]   nops;
    bit           chk_nops;
  } exp_t;

  logic clk;
  logic clr;
  int   n_vec;
  int   n_fail;
  exp_t sb[$];

  expr_eval_ctrl_if #(.W(W)) bus ();

  expr_eval_ctrl #(.W(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr && bus.res_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("res", 32'(bus.res), 32'(e.res));
          check("err", 32'(bus.err), 32'(e.err));
          if (e.chk_nops) check("nops", 32'(bus.nops), 32'(e.nops));
          check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
          check("busy_in_done", 32'(bus.busy), 32'd1);
        end
      end
    end
  end

  task automatic send(input logic [7:0] c, input int gap);
    int n;
    n = 0;
    bus.in       = c;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 20) begin
        check("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (c == 8'd61) begin
      @(negedge clk);
      check("latency", 32'(bus.res_valid), 32'd1);
    end
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic run_expr(input string s, input logic [W-1:0] r, input logic er,
                          input logic [7:0] np, input bit chk, input bit rnd);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      if (i == s.len() - 1) begin
        e.res = r; e.err = er; e.nops = np; e.chk_nops = chk;
        sb.push_back(e);
      end
      send(s[i], rnd ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  initial begin
    int n;
    n_vec = 0;
    n_fail = 0;
    bus.in_valid = 1'b0;
    bus.in = 8'd0;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_res", 32'(bus.res), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_nops", 32'(bus.nops), 32'd0);

    run_expr("3+4*5=", 16'd23, 1'b0, 8'd3, 1'b1, 1'b0);
    run_expr("2*3*4+1=", 16'd25, 1'b0, 8'd4, 1'b1, 1'b0);
    run_expr("7=", 16'd7, 1'b0, 8'd1, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_expr("=", 16'd0, 1'b1, 8'd0, 1'b0, 1'b0);
    run_expr("3+=", 16'd0, 1'b1, 8'd0, 1'b0, 1'b0);
    run_expr("3a5=", 16'd0, 1'b1, 8'd0, 1'b0, 1'b0);
    run_expr("+5=", 16'd0, 1'b1, 8'd0, 1'b0, 1'b0);
    run_expr("9*9*9*9*9*9=", 16'd7153, 1'b0, 8'd6, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send("1", 0);
    send("+", 0);
    send("2", 1);
    #3;
    clr = 1'b0;
    #1;
    check("clr_busy", 32'(bus.busy), 32'd0);
    check("clr_res", 32'(bus.res), 32'd0);
    check("clr_nops", 32'(bus.nops), 32'd0);
    check("clr_res_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("post_clr_in_ready", 32'(bus.in_ready), 32'd1);
    run_expr("4=", 16'd4, 1'b0, 8'd1, 1'b1, 1'b0);
    bus.in_valid = 1'b0;

    run_expr("8*0+6=", 16'd6, 1'b0, 8'd3, 1'b1, 1'b1);
    bus.in_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
